// File: rtl/apb_master_if.sv
// rtl/apb_master_if.sv - command, response and APB signal bundle for apb_master
//
// Groups the three streams around the APB requester:
//   cmd_*  : command stream into the master (valid/ready)
//   rsp_*  : buffered response stream out of the master (valid/ready)
//   p*     : APB requester outputs and slave response inputs
// Modports:
//   master : the apb_master view
//   slave  : the surrounding view (command source, response sink, APB slave)

interface apb_master_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   // command stream
   logic              cmd_valid;
   logic              cmd_ready;
   logic              cmd_write;
   logic [ADDR_W-1:0] cmd_addr;
   logic [DATA_W-1:0] cmd_wdata;

   // response stream
   logic              rsp_valid;
   logic              rsp_ready;
   logic [DATA_W-1:0] rsp_rdata;
   logic              rsp_err;
   logic              rsp_timeout;

   // APB
   logic              pselx;
   logic              penable;
   logic              pwrite;
   logic [ADDR_W-1:0] paddr;
   logic [DATA_W-1:0] pwdata;
   logic              pready;
   logic              pslverr;
   logic [DATA_W-1:0] prdata;

   modport master (
      input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
      output cmd_ready,
      output rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
      input  rsp_ready,
      output pselx, penable, pwrite, paddr, pwdata,
      input  pready, pslverr, prdata
   );

   modport slave (
      output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
      input  cmd_ready,
      input  rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
      output rsp_ready,
      input  pselx, penable, pwrite, paddr, pwdata,
      output pready, pslverr, prdata
   );
endinterface

// File: rtl/apb_master.sv
// rtl/apb_master.sv - single-outstanding APB requester with timeout guard
//
// Turns a valid/ready command stream into APB transfers and returns each
// transfer's outcome on a 2-entry buffered response stream.
// Ports:
//   pclk    : clock, all logic on the rising edge
//   preset  : synchronous active-high reset
//   bus     : apb_master_if.master
//             cmd_valid/cmd_ready/cmd_write/cmd_addr/cmd_wdata  command in
//             rsp_valid/rsp_ready/rsp_rdata/rsp_err/rsp_timeout response out
//             pselx/penable/pwrite/paddr/pwdata                 APB out (registered)
//             pready/pslverr/prdata                             APB slave response
// Parameters:
//   ADDR_W, DATA_W : bus widths (must match the interface instance)
//   TIMEOUT        : ACCESS cycles with pready=0 before abort, 0 = wait forever

module apb_master #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 16
) (
   input  logic          pclk,
   input  logic          preset,
   apb_master_if.master  bus
);

   // Counter only has to reach TIMEOUT-1; the TIMEOUT-th stalled cycle is
   // recognised by the compare, not by a further increment.
   localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SETUP  = 2'd1,
      S_ACCESS = 2'd2
   } state_t;

   state_t            state_q, state_d;

   // one-entry command buffer
   logic              buf_full_q;
   logic              buf_write_q;
   logic [ADDR_W-1:0] buf_addr_q;
   logic [DATA_W-1:0] buf_wdata_q;

   // registered APB outputs
   logic              psel_q;
   logic              penable_q;
   logic              pwrite_q;
   logic [ADDR_W-1:0] paddr_q;
   logic [DATA_W-1:0] pwdata_q;

   // wait-state timer
   logic [TW-1:0]     tmo_cnt_q, tmo_cnt_d;
   logic              tmo_hit;

   // two-entry response FIFO
   logic [DATA_W-1:0] fifo_rdata [2];
   logic              fifo_err   [2];
   logic              fifo_tmo   [2];
   logic              wr_ptr_q;
   logic              rd_ptr_q;
   logic [1:0]        count_q;

   // handshakes and FSM decisions
   logic              cmd_ready;
   logic              accept;
   logic              rsp_valid;
   logic              pop;
   logic              launch;
   logic              can_launch;
   logic              push;
   logic [DATA_W-1:0] push_rdata;
   logic              push_err;
   logic              push_tmo;
   logic [1:0]        occ_after;

   // ------------------------------------------------------------------
   // Handshakes
   // ------------------------------------------------------------------
   // The buffer can take a new command in the same cycle it hands its
   // current one to SETUP, which is what makes back-to-back transfers work.
   assign cmd_ready = !preset && (!buf_full_q || launch);
   assign accept    = bus.cmd_valid && cmd_ready;

   assign rsp_valid = !preset && (count_q != 2'd0);
   assign pop       = rsp_valid && bus.rsp_ready;

   generate
      if (TIMEOUT > 0) begin : g_tmo
         localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
         assign tmo_hit = (tmo_cnt_q == TMO_LAST);
      end else begin : g_no_tmo
         assign tmo_hit = 1'b0;
      end
   endgenerate

   // ------------------------------------------------------------------
   // FSM: next state, completion push and launch decision
   // ------------------------------------------------------------------
   always_comb begin
      state_d    = state_q;
      tmo_cnt_d  = tmo_cnt_q;
      push       = 1'b0;
      push_rdata = '0;
      push_err   = 1'b0;
      push_tmo   = 1'b0;
      launch     = 1'b0;

      // Completion is resolved first because the launch rule needs this
      // cycle's push. A late pready beats the timeout in the same cycle.
      if (state_q == S_ACCESS) begin
         if (bus.pready) begin
            push       = 1'b1;
            push_rdata = pwrite_q ? '0 : bus.prdata;
            push_err   = bus.pslverr;
         end else if (tmo_hit) begin
            push     = 1'b1;
            push_err = 1'b1;
            push_tmo = 1'b1;
         end else begin
            tmo_cnt_d = tmo_cnt_q + 1'b1;
         end
      end

      // A launch reserves a FIFO slot for the transfer it starts, so it is
      // only allowed when the FIFO will not be full after this edge.
      occ_after  = count_q + {1'b0, push} - {1'b0, pop};
      can_launch = buf_full_q && (occ_after < 2'd2);

      case (state_q)
         S_IDLE: begin
            if (can_launch) begin
               state_d = S_SETUP;
               launch  = 1'b1;
            end
         end
         S_SETUP: begin
            state_d   = S_ACCESS;
            tmo_cnt_d = '0;
         end
         S_ACCESS: begin
            if (push) begin
               if (can_launch) begin
                  state_d = S_SETUP;
                  launch  = 1'b1;
               end else begin
                  state_d = S_IDLE;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge pclk) begin
      if (preset) begin
         state_q   <= S_IDLE;
         tmo_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         tmo_cnt_q <= tmo_cnt_d;
      end
   end

   // ------------------------------------------------------------------
   // APB output registers
   // ------------------------------------------------------------------
   // Control is registered from the next state so pselx/penable change
   // exactly at the state edge; address/data only move on a launch and
   // otherwise hold their last values through IDLE and ACCESS.
   always_ff @(posedge pclk) begin
      if (preset) begin
         psel_q    <= 1'b0;
         penable_q <= 1'b0;
         pwrite_q  <= 1'b0;
         paddr_q   <= '0;
         pwdata_q  <= '0;
      end else begin
         psel_q    <= (state_d != S_IDLE);
         penable_q <= (state_d == S_ACCESS);
         if (launch) begin
            pwrite_q <= buf_write_q;
            paddr_q  <= buf_addr_q;
            pwdata_q <= buf_wdata_q;
         end
      end
   end

   // ------------------------------------------------------------------
   // Command buffer
   // ------------------------------------------------------------------
   always_ff @(posedge pclk) begin
      if (preset) begin
         buf_full_q  <= 1'b0;
         buf_write_q <= 1'b0;
         buf_addr_q  <= '0;
         buf_wdata_q <= '0;
      end else begin
         if (accept) begin
            buf_full_q  <= 1'b1;
            buf_write_q <= bus.cmd_write;
            buf_addr_q  <= bus.cmd_addr;
            buf_wdata_q <= bus.cmd_wdata;
         end else if (launch) begin
            buf_full_q  <= 1'b0;
         end
      end
   end

   // ------------------------------------------------------------------
   // Response FIFO
   // ------------------------------------------------------------------
   always_ff @(posedge pclk) begin
      if (preset) begin
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else begin
         if (push) wr_ptr_q <= ~wr_ptr_q;
         if (pop)  rd_ptr_q <= ~rd_ptr_q;
         count_q <= occ_after;
      end
   end

   // Storage needs no reset: the outputs are gated by rsp_valid.
   always_ff @(posedge pclk) begin
      if (push) begin
         fifo_rdata[wr_ptr_q] <= push_rdata;
         fifo_err[wr_ptr_q]   <= push_err;
         fifo_tmo[wr_ptr_q]   <= push_tmo;
      end
   end

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   assign bus.cmd_ready   = cmd_ready;
   assign bus.rsp_valid   = rsp_valid;
   assign bus.rsp_rdata   = rsp_valid ? fifo_rdata[rd_ptr_q] : '0;
   assign bus.rsp_err     = rsp_valid && fifo_err[rd_ptr_q];
   assign bus.rsp_timeout = rsp_valid && fifo_tmo[rd_ptr_q];

   assign bus.pselx       = psel_q;
   assign bus.penable     = penable_q;
   assign bus.pwrite      = pwrite_q;
   assign bus.paddr       = paddr_q;
   assign bus.pwdata      = pwdata_q;

endmodule

// File: tb/tb_apb_master.sv
// tb/tb_apb_master.sv - scoreboard bench for apb_master with a small APB slave model

module tb_apb_master;

   localparam int AW  = 32;
   localparam int DW  = 32;
   localparam int TMO = 4;

   logic pclk = 1'b0;
   logic preset;

   always #5 pclk = ~pclk;

   apb_master_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

   apb_master #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TMO)) dut (
      .pclk   (pclk),
      .preset (preset),
      .bus    (bus)
   );

   typedef struct packed {
      logic [DW-1:0] rdata;
      logic          err;
      logic          tmo;
   } rsp_t;

   rsp_t          exp_q[$];
   rsp_t          obs_q[$];
   bit            psel_h[$];
   bit            pen_h[$];
   bit            rv_h[$];
   bit            last_acc;
   logic [DW-1:0] exp_mem [0:15];
   int            total = 0;
   int            bad   = 0;

   // APB slave model: memory with programmable wait states, error and hang
   int            s_wait  = 0;
   bit            s_stuck = 1'b0;
   bit            s_err   = 1'b0;
   logic [DW-1:0] smem [0:15];
   int            wcnt = 0;

   always @(posedge pclk) begin
      if (bus.pselx && bus.penable && !bus.pready) wcnt <= wcnt + 1;
      else wcnt <= 0;
      if (bus.pselx && bus.penable && bus.pready && bus.pwrite)
         smem[bus.paddr[5:2]] <= bus.pwdata;
   end

   assign bus.pready  = bus.pselx & bus.penable & !s_stuck & (wcnt >= s_wait);
   assign bus.prdata  = smem[bus.paddr[5:2]];
   assign bus.pslverr = s_err;

   // one cycle: sample at the falling edge, return 1 time unit after the rising edge
   task automatic tick();
      rsp_t r;
      @(negedge pclk);
      psel_h.push_back(bus.pselx);
      pen_h.push_back(bus.penable);
      rv_h.push_back(bus.rsp_valid);
      last_acc = bus.cmd_valid & bus.cmd_ready;
      if (bus.rsp_valid && bus.rsp_ready) begin
         r.rdata = bus.rsp_rdata;
         r.err   = bus.rsp_err;
         r.tmo   = bus.rsp_timeout;
         obs_q.push_back(r);
      end
      @(posedge pclk);
      #1;
   endtask

   // offer one command until accepted; on acceptance push the expected response
   task automatic send(input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input bit e_err, input bit e_tmo, input bit keep, output bit ok);
      rsp_t e;
      bus.cmd_valid = 1'b1;
      bus.cmd_write = w;
      bus.cmd_addr  = a;
      bus.cmd_wdata = d;
      ok = 1'b0;
      for (int i = 0; i < 40 && !ok; i++) begin
         tick();
         ok = last_acc;
      end
      bus.cmd_valid = 1'b0;
      if (ok) begin
         if (keep) begin
            e.rdata = (w || e_tmo) ? '0 : exp_mem[a[5:2]];
            e.err   = e_err;
            e.tmo   = e_tmo;
            exp_q.push_back(e);
         end
         if (w && !e_tmo) exp_mem[a[5:2]] = d;
      end
   endtask

   task automatic test_reset();
      preset = 1'b1;
      tick();
      tick();
      total++;
      if ({bus.pselx, bus.penable, bus.pwrite, bus.rsp_valid, bus.rsp_err, bus.rsp_timeout, bus.cmd_ready} !== 7'b0) begin
         bad++;
         $display("FAIL reset_ctrl: got psel=%b pen=%b pwr=%b rv=%b err=%b to=%b crdy=%b, required all 0",
                  bus.pselx, bus.penable, bus.pwrite, bus.rsp_valid, bus.rsp_err, bus.rsp_timeout, bus.cmd_ready);
      end
      total++;
      if (bus.paddr !== '0 || bus.pwdata !== '0) begin
         bad++;
         $display("FAIL reset_bus: got paddr=%h pwdata=%h, required 0", bus.paddr, bus.pwdata);
      end
      total++;
      if (bus.rsp_rdata !== '0) begin
         bad++;
         $display("FAIL reset_rdata: got %h, required 0", bus.rsp_rdata);
      end
      preset = 1'b0;
      #1;
      total++;
      if (bus.cmd_ready !== 1'b1) begin
         bad++;
         $display("FAIL reset_release_ready: got %b, required 1", bus.cmd_ready);
      end
      tick();
   endtask

   task automatic test_single_write();
      bit ok;
      int idx;
      bus.rsp_ready = 1'b1;
      s_wait = 0;
      send(1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 1'b0, 1'b1, ok);
      idx = psel_h.size();
      repeat (6) tick();
      total++;
      if (!ok) begin bad++; $display("FAIL single_accept: got not accepted, required accepted"); end
      total++;
      if ({psel_h[idx], psel_h[idx+1], psel_h[idx+2], psel_h[idx+3]} !== 4'b0110) begin
         bad++;
         $display("FAIL single_psel: got %b%b%b%b, required 0110", psel_h[idx], psel_h[idx+1], psel_h[idx+2], psel_h[idx+3]);
      end
      total++;
      if ({pen_h[idx], pen_h[idx+1], pen_h[idx+2], pen_h[idx+3]} !== 4'b0010) begin
         bad++;
         $display("FAIL single_penable: got %b%b%b%b, required 0010", pen_h[idx], pen_h[idx+1], pen_h[idx+2], pen_h[idx+3]);
      end
      total++;
      if ({rv_h[idx], rv_h[idx+1], rv_h[idx+2], rv_h[idx+3]} !== 4'b0001) begin
         bad++;
         $display("FAIL single_latency: rsp_valid got %b%b%b%b, required 0001", rv_h[idx], rv_h[idx+1], rv_h[idx+2], rv_h[idx+3]);
      end
      while (exp_q.size() != 0) begin
         rsp_t e, o;
         e = exp_q.pop_front();
         total++;
         if (obs_q.size() == 0) begin
            bad++; $display("FAIL single_rsp: got no response, required %h/%b/%b", e.rdata, e.err, e.tmo);
         end else begin
            o = obs_q.pop_front();
            if (o !== e) begin bad++; $display("FAIL single_rsp: got %h/%b/%b, required %h/%b/%b", o.rdata, o.err, o.tmo, e.rdata, e.err, e.tmo); end
         end
      end
   endtask

   task automatic test_read_wait();
      bit ok;
      int idx;
      int n;
      s_wait = 2;
      send(1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 1'b1, ok);
      idx = psel_h.size();
      repeat (10) tick();
      s_wait = 0;
      n = 0;
      for (int i = idx; i < pen_h.size(); i++) n += int'(pen_h[i]);
      total++;
      if (!ok || n != 3) begin
         bad++; $display("FAIL read_wait_penable: got %0d cycles (accepted=%b), required 3", n, ok);
      end
      total++;
      if ({rv_h[idx+4], rv_h[idx+5]} !== 2'b01) begin
         bad++; $display("FAIL read_wait_latency: rsp_valid at +4,+5 got %b%b, required 01", rv_h[idx+4], rv_h[idx+5]);
      end
      while (exp_q.size() != 0) begin
         rsp_t e, o;
         e = exp_q.pop_front();
         total++;
         if (obs_q.size() == 0) begin
            bad++; $display("FAIL read_wait_rsp: got no response, required %h/%b/%b", e.rdata, e.err, e.tmo);
         end else begin
            o = obs_q.pop_front();
            if (o !== e) begin bad++; $display("FAIL read_wait_rsp: got %h/%b/%b, required %h/%b/%b", o.rdata, o.err, o.tmo, e.rdata, e.err, e.tmo); end
         end
      end
   endtask

   task automatic test_back_to_back();
      bit ok_a, ok_b;
      int idx, n0, dn;
      logic [5:0] ps, pe;
      bus.rsp_ready = 1'b1;
      send(1'b1, 32'h20, 32'h11111111, 1'b0, 1'b0, 1'b1, ok_a);
      idx = psel_h.size();
      n0  = psel_h.size();
      send(1'b0, 32'h20, 32'h0, 1'b0, 1'b0, 1'b1, ok_b);
      dn = psel_h.size() - n0;
      repeat (6) tick();
      total++;
      if (!ok_a || !ok_b || dn != 1) begin
         bad++; $display("FAIL b2b_accept: second command took %0d cycles (ok=%b%b), required 1", dn, ok_a, ok_b);
      end
      ps = {psel_h[idx], psel_h[idx+1], psel_h[idx+2], psel_h[idx+3], psel_h[idx+4], psel_h[idx+5]};
      pe = {pen_h[idx], pen_h[idx+1], pen_h[idx+2], pen_h[idx+3], pen_h[idx+4], pen_h[idx+5]};
      total++;
      if (ps !== 6'b011110) begin bad++; $display("FAIL b2b_psel: got %b, required 011110", ps); end
      total++;
      if (pe !== 6'b001010) begin bad++; $display("FAIL b2b_penable: got %b, required 001010", pe); end
      while (exp_q.size() != 0) begin
         rsp_t e, o;
         e = exp_q.pop_front();
         total++;
         if (obs_q.size() == 0) begin
            bad++; $display("FAIL b2b_rsp: got no response, required %h/%b/%b", e.rdata, e.err, e.tmo);
         end else begin
            o = obs_q.pop_front();
            if (o !== e) begin bad++; $display("FAIL b2b_rsp: got %h/%b/%b, required %h/%b/%b", o.rdata, o.err, o.tmo, e.rdata, e.err, e.tmo); end
         end
      end
   endtask

   task automatic test_backpressure();
      bit ok1, ok2, ok3;
      bit refused, launched;
      bus.rsp_ready = 1'b0;
      send(1'b1, 32'h04, 32'hA5A50001, 1'b0, 1'b0, 1'b1, ok1);
      send(1'b1, 32'h08, 32'h5A5A0002, 1'b0, 1'b0, 1'b1, ok2);
      send(1'b0, 32'h04, 32'h0, 1'b0, 1'b0, 1'b1, ok3);
      bus.cmd_valid = 1'b1;
      bus.cmd_write = 1'b1;
      bus.cmd_addr  = 32'h0C;
      bus.cmd_wdata = 32'h0000CAFE;
      refused = 1'b1;
      repeat (8) begin
         tick();
         if (last_acc) refused = 1'b0;
      end
      total++;
      if (!(ok1 && ok2 && ok3) || !refused) begin
         bad++; $display("FAIL bp_accept: got ok=%b%b%b refused4=%b, required 111 1", ok1, ok2, ok3, refused);
      end
      total++;
      if ({bus.pselx, bus.cmd_ready, bus.rsp_valid} !== 3'b001) begin
         bad++; $display("FAIL bp_hold: got psel=%b crdy=%b rv=%b, required 0 0 1", bus.pselx, bus.cmd_ready, bus.rsp_valid);
      end
      total++;
      if (obs_q.size() != 0) begin bad++; $display("FAIL bp_no_pop: got %0d responses taken, required 0", obs_q.size()); end
      bus.cmd_valid = 1'b0;
      bus.rsp_ready = 1'b1;
      launched = 1'b0;
      repeat (3) begin
         tick();
         if (bus.pselx) launched = 1'b1;
      end
      total++;
      if (!launched) begin bad++; $display("FAIL bp_release: got no launch, required third transfer launched"); end
      repeat (8) tick();
      while (exp_q.size() != 0) begin
         rsp_t e, o;
         e = exp_q.pop_front();
         total++;
         if (obs_q.size() == 0) begin
            bad++; $display("FAIL bp_rsp: got no response, required %h/%b/%b", e.rdata, e.err, e.tmo);
         end else begin
            o = obs_q.pop_front();
            if (o !== e) begin bad++; $display("FAIL bp_rsp: got %h/%b/%b, required %h/%b/%b", o.rdata, o.err, o.tmo, e.rdata, e.err, e.tmo); end
         end
      end
   endtask

   task automatic test_timeout();
      bit ok;
      int idx, n;
      bus.rsp_ready = 1'b1;
      s_stuck = 1'b1;
      send(1'b0, 32'h30, 32'h0, 1'b1, 1'b1, 1'b1, ok);
      idx = psel_h.size();
      repeat (10) tick();
      s_stuck = 1'b0;
      n = 0;
      for (int i = idx; i < pen_h.size(); i++) n += int'(pen_h[i]);
      total++;
      if (!ok || n != TMO) begin bad++; $display("FAIL timeout_penable: got %0d cycles (accepted=%b), required %0d", n, ok, TMO); end
      total++;
      if ({psel_h[idx+5], psel_h[idx+6], pen_h[idx+6]} !== 3'b100) begin
         bad++; $display("FAIL timeout_idle: got psel=%b,%b pen=%b, required 1,0 0", psel_h[idx+5], psel_h[idx+6], pen_h[idx+6]);
      end
      while (exp_q.size() != 0) begin
         rsp_t e, o;
         e = exp_q.pop_front();
         total++;
         if (obs_q.size() == 0) begin
            bad++; $display("FAIL timeout_rsp: got no response, required %h/%b/%b", e.rdata, e.err, e.tmo);
         end else begin
            o = obs_q.pop_front();
            if (o !== e) begin bad++; $display("FAIL timeout_rsp: got %h/%b/%b, required %h/%b/%b", o.rdata, o.err, o.tmo, e.rdata, e.err, e.tmo); end
         end
      end
   endtask

   task automatic test_slverr_reset();
      bit ok1, ok2, ok3;
      bus.rsp_ready = 1'b1;
      s_err = 1'b1;
      send(1'b1, 32'h34, 32'h00000BAD, 1'b1, 1'b0, 1'b1, ok1);
      repeat (6) tick();
      s_err = 1'b0;
      while (exp_q.size() != 0) begin
         rsp_t e, o;
         e = exp_q.pop_front();
         total++;
         if (obs_q.size() == 0) begin
            bad++; $display("FAIL slverr_rsp: got no response, required %h/%b/%b", e.rdata, e.err, e.tmo);
         end else begin
            o = obs_q.pop_front();
            if (o !== e) begin bad++; $display("FAIL slverr_rsp: got %h/%b/%b, required %h/%b/%b", o.rdata, o.err, o.tmo, e.rdata, e.err, e.tmo); end
         end
      end
      // leave one response parked in the FIFO, then hang a read in ACCESS
      bus.rsp_ready = 1'b0;
      send(1'b1, 32'h38, 32'h00001234, 1'b0, 1'b0, 1'b0, ok2);
      repeat (5) tick();
      s_stuck = 1'b1;
      send(1'b0, 32'h3C, 32'h0, 1'b0, 1'b0, 1'b0, ok3);
      tick();
      tick();
      total++;
      if (!(ok1 && ok2 && ok3) || {bus.pselx, bus.penable, bus.rsp_valid} !== 3'b111) begin
         bad++; $display("FAIL rst_pre: got psel=%b pen=%b rv=%b ok=%b%b%b, required 1 1 1 111",
                         bus.pselx, bus.penable, bus.rsp_valid, ok1, ok2, ok3);
      end
      preset = 1'b1;
      tick();
      total++;
      if ({bus.pselx, bus.penable, bus.rsp_valid} !== 3'b000) begin
         bad++; $display("FAIL rst_mid: got psel=%b pen=%b rv=%b, required 0 0 0", bus.pselx, bus.penable, bus.rsp_valid);
      end
      preset = 1'b0;
      s_stuck = 1'b0;
      bus.rsp_ready = 1'b1;
      repeat (6) tick();
      total++;
      if (obs_q.size() != 0 || bus.pselx !== 1'b0) begin
         bad++; $display("FAIL rst_drop: got %0d stale responses psel=%b, required 0 0", obs_q.size(), bus.pselx);
      end
   endtask

   initial begin
      preset        = 1'b1;
      bus.cmd_valid = 1'b0;
      bus.cmd_write = 1'b0;
      bus.cmd_addr  = '0;
      bus.cmd_wdata = '0;
      bus.rsp_ready = 1'b0;
      test_reset();
      test_single_write();
      test_read_wait();
      test_back_to_back();
      test_backpressure();
      test_timeout();
      test_slverr_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/apb_master.md
# apb_master

Single-outstanding APB requester that turns a simple valid/ready command stream into APB transfers on `pselx`/`penable`/`paddr`/`pwrite`/`pwdata`. It sits directly upstream of the APB memory slave and consumes its `pready`/`prdata`/`pslverr` response. Each transfer's result is returned on a buffered valid/ready response stream. A wait-state timeout guard keeps a hung slave from stalling the master.

## Interface
- `ADDR_W`, 32, width of `paddr`/`cmd_addr`
- `DATA_W`, 32, width of all data buses
- `TIMEOUT`, 16, maximum number of ACCESS cycles with `pready`=0 before the transfer is aborted; 0 disables the guard

- `pclk` in 1: clock, all logic on rising edge
- `preset` in 1: synchronous, active-high reset
- `cmd_valid` in 1: command present
- `cmd_ready` out 1: command accepted when `cmd_valid`&`cmd_ready` at an edge
- `cmd_write` in 1: 1 = write, 0 = read
- `cmd_addr` in ADDR_W: transfer address
- `cmd_wdata` in DATA_W: write data
- `rsp_valid` out 1: response FIFO head valid
- `rsp_ready` in 1: response consumed when `rsp_valid`&`rsp_ready` at an edge
- `rsp_rdata` out DATA_W: read data (0 for writes and timeouts)
- `rsp_err` out 1: slave error or timeout
- `rsp_timeout` out 1: transfer aborted by the timeout guard
- `pselx`, `penable`, `pwrite` out 1: APB control outputs, registered
- `paddr` out ADDR_W, `pwdata` out DATA_W: APB address and write data, registered
- `pready`, `pslverr` in 1; `prdata` in DATA_W: APB slave response

## Operation
- **Reset.** While `preset` is high, all APB outputs and response outputs are 0. `cmd_ready`=0. The command buffer and response FIFO are emptied.
- **Reset mid-transfer.** The transfer is dropped without a response. `pselx`/`penable` are low after the reset edge.
- **Command buffer (1 entry).**
  - `cmd_ready` = !preset & (buffer empty | buffer launching this cycle).
- **Response FIFO (2 entries).**
  - The head is presented on `rsp_*`.
  - Push and pop in the same cycle are both allowed.
- **State machine.**
  - IDLE: `pselx`=0, `penable`=0. `paddr`, `pwdata` and `pwrite` hold their last values.
  - SETUP: `pselx`=1, `penable`=0, and the address/control/data are loaded from the buffer. SETUP always lasts exactly one cycle, then goes to ACCESS.
  - ACCESS: `pselx`=1, `penable`=1, with all APB outputs stable.
- **Completion.** An ACCESS cycle with `pready`=1 completes the transfer. At that edge one entry is pushed: `rdata` = `prdata` for a read or 0 for a write; `err` = `pslverr`; `timeout` = 0.
- **Launch rule.** A transition to SETUP (from IDLE, or directly from a completing ACCESS) requires:
  - the buffer is full, and
  - FIFO occupancy after this cycle's push and pop is below 2.
- **After completion without launch.** The state goes to IDLE.
- **Back-to-back transfers.** ACCESS→SETUP keeps `pselx` high and drops `penable` for one cycle.
- **Timeout** (TIMEOUT>0).
  - A counter is cleared on entry to ACCESS and increments on each ACCESS cycle with `pready`=0.
  - The TIMEOUT-th such cycle ends the transfer. Push `rdata`=0, `err`=1, `timeout`=1, then go to IDLE or SETUP under the launch rule.
  - `pready` arriving in that same cycle takes priority: the transfer completes normally.
- **TIMEOUT=0.** The master waits indefinitely.
- **Write data.** `pwdata` is driven for reads as well, holding the buffered `cmd_wdata`. The slave ignores it.

## Timing
- The command handshake at edge E0 fills the buffer. SETUP is registered at E1 and ACCESS at E2.
- With a zero-wait slave, completion is at E3 and `rsp_valid`=1 from E3.
  - Command-to-response latency is 3 edges, plus 1 per wait state.
- The response FIFO never overflows: the launch rule reserves a slot for every transfer in flight.
- With `rsp_ready` held low, at most 2 transfers complete. One more command waits in the buffer, and `cmd_ready` then stays 0.
- Sustained throughput with `rsp_ready`=1 and a zero-wait slave is one transfer per 2 cycles.

## Test plan
- **Single write.** Reset, then write 0xDEADBEEF to 0x10 with `pready`=1 → one SETUP cycle and one ACCESS cycle. `rsp_valid`=1 three edges after accept, with `rsp_rdata`=0 and `rsp_err`=0.
- **Read with wait states.** Read 0x10; the slave inserts 2 wait states, then returns 0xDEADBEEF → `penable` high for 3 cycles, `rsp_rdata`=0xDEADBEEF.
- **Back-to-back.** Two commands with `rsp_ready`=1 → `pselx` high for 4 consecutive cycles, `penable` pattern 0,1,0,1, and no IDLE cycle between the transfers.
- **Backpressure.** Hold `rsp_ready`=0 and offer 4 commands → 2 responses are queued and the 3rd stays buffered with `pselx`=0. The 4th is refused (`cmd_ready`=0). Raising `rsp_ready` launches the 3rd transfer.
- **Timeout.** TIMEOUT=4 with `pready` stuck at 0 → `penable` high for exactly 4 cycles, then `pselx`=`penable`=0. The response has `rsp_err`=1, `rsp_timeout`=1, `rsp_rdata`=0.
- **Slave error and reset.**
  - `pslverr`=1 on completion → `rsp_err`=1, `rsp_timeout`=0.
  - `preset` asserted in ACCESS → `pselx`, `penable` and `rsp_valid` are 0 after the next edge.
